regfile_dump: RTL and testbench

//  Reader-side companion to the MIPS register file: walks a range of registers through one

---
 rtl/regfile_dump_pkg.sv | 12 +
 rtl/regfile_dump.sv | 90 +++++++++
 tb/tb_regfile_dump.sv | 310 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/regfile_dump_pkg.sv
// regfile_dump_pkg: shared FSM encoding and register file geometry for the dump walker
package regfile_dump_pkg;
  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;
  localparam int REG_COUNT = 32;
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;
endpackage

// File: rtl/regfile_dump.sv
// regfile_dump: walks a register range through one async read port and streams values over valid/ready
module regfile_dump
  import regfile_dump_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] first_reg,
  input  logic [ADDR_W-1:0] last_reg,
  output logic [ADDR_W-1:0] rd_path,
  input  logic [DATA_W-1:0] rd_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [ADDR_W-1:0] out_index,
  output logic              out_last,
  output logic              busy,
  output logic              done
);
  state_t            state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [ADDR_W:0]   remain_q, remain_d;
  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic [ADDR_W-1:0] out_index_q, out_index_d;
  logic              out_last_q, out_last_d;
  logic              cap, is_last;
  assign cap = !out_valid_q || out_ready;
  assign is_last = remain_q == (ADDR_W+1)'(1);
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    remain_d    = remain_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_index_d = out_index_q;
    out_last_d  = out_last_q;
    unique case (state_q)
      IDLE: if (start) begin
        ptr_d    = first_reg;
        remain_d = {1'b0, last_reg - first_reg} + (ADDR_W+1)'(1);
        state_d  = RUN;
      end
      RUN: if (cap) begin
        out_data_d  = rd_data;
        out_index_d = ptr_q;
        out_last_d  = is_last;
        out_valid_d = 1'b1;
        remain_d    = remain_q - (ADDR_W+1)'(1);
        // pointer freezes on the final register so rd_path holds through DRAIN/DONE/IDLE
        state_d     = is_last ? DRAIN : RUN;
        ptr_d       = is_last ? ptr_q : ptr_q + ADDR_W'(1);
      end
      DRAIN: if (out_ready) begin
        out_valid_d = 1'b0;
        state_d     = DONE;
      end
      DONE: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      remain_q    <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_index_q <= '0;
      out_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      remain_q    <= remain_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_index_q <= out_index_d;
      out_last_q  <= out_last_d;
    end
  end
  assign rd_path   = ptr_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_index = out_index_q;
  assign out_last  = out_last_q;
  assign busy      = state_q != IDLE;
  assign done      = state_q == DONE;
endmodule

// File: tb/tb_regfile_dump.sv
// tb_regfile_dump: scoreboard bench for regfile_dump with a behavioural register file beside it
module tb_regfile_dump;
  logic        clock, reset_n, start, out_ready;
  logic [4:0]  first_reg, last_reg, rd_path, out_index;
  logic [31:0] rd_data, out_data;
  logic        out_valid, out_last, busy, done;
  logic [31:0] regs [32];
  logic        we;
  logic [4:0]  wa;
  logic [31:0] wd;
  logic [37:0] sb [$];
  logic [37:0] held;
  logic        held_v;
  logic [31:0] last_data;
  int n_cmp, n_err, acc_cnt, done_cnt;

  regfile_dump dut (
    .clock(clock), .reset_n(reset_n), .start(start), .first_reg(first_reg), .last_reg(last_reg),
    .rd_path(rd_path), .rd_data(rd_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_index(out_index), .out_last(out_last), .busy(busy), .done(done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  assign rd_data = regs[rd_path];
  always @(posedge clock) if (we) regs[wa] <= wd;

  always @(negedge clock) begin
    if (done) begin
      done_cnt++;
      n_cmp++;
      if (out_valid) begin
        n_err++;
        $display("FAIL done_with_valid: out_valid=%0b required 0 while done", out_valid);
      end
    end
    if (held_v && out_valid) begin
      n_cmp++;
      if ({out_data, out_index, out_last} !== held) begin
        n_err++;
        $display("FAIL beat_stable: got %h required %h", {out_data, out_index, out_last}, held);
      end
    end
    held_v = out_valid && !out_ready;
    held = {out_data, out_index, out_last};
    if (out_valid && out_ready) begin
      acc_cnt++;
      last_data = out_data;
      n_cmp++;
      if (sb.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_beat: got idx=%0d data=%h, none expected", out_index, out_data);
      end else begin
        automatic logic [37:0] e = sb.pop_front();
        if ({out_data, out_index, out_last} !== e) begin
          n_err++;
          $display("FAIL beat: got data=%h idx=%0d last=%0b required data=%h idx=%0d last=%0b",
                   out_data, out_index, out_last, e[37:6], e[5:1], e[0]);
        end
      end
    end
  end

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic do_start(input logic [4:0] f, input logic [4:0] l);
    logic [4:0] span, idx;
    span = l - f;
    for (int i = 0; i <= int'(span); i++) begin
      idx = f + 5'(i);
      sb.push_back({regs[idx], idx, i == int'(span)});
    end
    first_reg = f;
    last_reg = l;
    start = 1'b1;
    tick;
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, input bit poke, output int cycles);
    cycles = 0;
    while (!done && cycles < budget) begin
      tick;
      cycles++;
    end
    n_cmp++;
    if (!done) begin
      n_err++;
      $display("FAIL done_timeout: done=%0b after %0d cycles, required 1", done, cycles);
    end
    if (poke) begin
      first_reg = 5'd0;
      last_reg = 5'd31;
      start = 1'b1;
    end
    tick;
    start = 1'b0;
  endtask

  task automatic test_reset;
    n_cmp++;
    if ({rd_path, out_valid, out_data, out_index, out_last, busy, done} !== '0) begin
      n_err++;
      $display("FAIL reset_in: got %h required 0", {rd_path, out_valid, out_data, out_index, out_last, busy, done});
    end
    #4 reset_n = 1'b1;
    tick;
    tick;
    n_cmp++;
    if ({out_valid, busy, done} !== 3'b000) begin
      n_err++;
      $display("FAIL reset_out: valid/busy/done=%b required 000", {out_valid, busy, done});
    end
  endtask

  task automatic test_full;
    int cyc, d0, a0;
    for (int i = 0; i < 32; i++) regs[i] = 32'hA500_0000 + i;
    out_ready = 1'b1;
    d0 = done_cnt;
    a0 = acc_cnt;
    do_start(5'd0, 5'd31);
    n_cmp++;
    if ({busy, out_valid} !== 2'b10) begin
      n_err++;
      $display("FAIL full_latency: busy/valid=%b required 10", {busy, out_valid});
    end
    wait_done(60, 1'b0, cyc);
    n_cmp++;
    if (cyc !== 33) begin
      n_err++;
      $display("FAIL full_cycles: got %0d required 33", cyc);
    end
    n_cmp++;
    if (acc_cnt - a0 !== 32 || done_cnt - d0 !== 1 || sb.size() !== 0 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL full_end: beats=%0d done=%0d left=%0d busy=%0b required 32/1/0/0",
               acc_cnt - a0, done_cnt - d0, sb.size(), busy);
    end
  endtask

  task automatic test_wrap;
    int cyc, a0;
    a0 = acc_cnt;
    do_start(5'd29, 5'd2);
    wait_done(20, 1'b0, cyc);
    n_cmp++;
    if (cyc !== 7 || acc_cnt - a0 !== 6 || sb.size() !== 0) begin
      n_err++;
      $display("FAIL wrap: cycles=%0d beats=%0d left=%0d required 7/6/0", cyc, acc_cnt - a0, sb.size());
    end
  endtask

  task automatic test_single_stall;
    int cyc, d0;
    d0 = done_cnt;
    out_ready = 1'b0;
    do_start(5'd7, 5'd7);
    tick;
    n_cmp++;
    if ({out_valid, out_index, out_last} !== {1'b1, 5'd7, 1'b1}) begin
      n_err++;
      $display("FAIL single_beat: valid/idx/last=%b/%0d/%b required 1/7/1", out_valid, out_index, out_last);
    end
    tick;
    tick;
    n_cmp++;
    if ({out_valid, out_index, done} !== {1'b1, 5'd7, 1'b0}) begin
      n_err++;
      $display("FAIL single_hold: valid/idx/done=%b/%0d/%b required 1/7/0", out_valid, out_index, done);
    end
    out_ready = 1'b1;
    wait_done(10, 1'b0, cyc);
    n_cmp++;
    if (done_cnt - d0 !== 1 || sb.size() !== 0) begin
      n_err++;
      $display("FAIL single_end: done=%0d left=%0d required 1/0", done_cnt - d0, sb.size());
    end
  endtask

  task automatic test_back_pressure;
    int cyc, n, a0;
    a0 = acc_cnt;
    out_ready = 1'b1;
    do_start(5'd4, 5'd9);
    n = 0;
    while (!(out_valid && out_index == 5'd5) && n < 10) begin
      tick;
      n++;
    end
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      start = (i == 1);
      first_reg = 5'd0;
      last_reg = 5'd31;
      tick;
    end
    start = 1'b0;
    n_cmp++;
    if ({out_valid, out_index} !== {1'b1, 5'd5}) begin
      n_err++;
      $display("FAIL stall_hold: valid/idx=%b/%0d required 1/5", out_valid, out_index);
    end
    out_ready = 1'b1;
    wait_done(20, 1'b1, cyc);
    n_cmp++;
    if (busy !== 1'b0 || out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL start_in_done: busy/valid=%b%b required 00", busy, out_valid);
    end
    tick;
    n_cmp++;
    if (acc_cnt - a0 !== 6 || sb.size() !== 0 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL stall_end: beats=%0d left=%0d busy=%0b required 6/0/0", acc_cnt - a0, sb.size(), busy);
    end
  endtask

  task automatic test_coherency;
    int cyc, n;
    do_start(5'd4, 5'd9);
    n = 0;
    while (rd_path !== 5'd6 && n < 10) begin
      tick;
      n++;
    end
    we = 1'b1;
    wa = 5'd6;
    wd = 32'hFFFF_FFFF;
    tick;
    we = 1'b0;
    wait_done(20, 1'b0, cyc);
    do_start(5'd6, 5'd6);
    wait_done(10, 1'b0, cyc);
    n_cmp++;
    if (last_data !== 32'hFFFF_FFFF || sb.size() !== 0) begin
      n_err++;
      $display("FAIL coherency_new: got %h required ffffffff (left=%0d)", last_data, sb.size());
    end
  endtask

  task automatic test_reset_mid;
    int cyc, n, a0;
    do_start(5'd0, 5'd31);
    n = 0;
    while (!(out_valid && out_index == 5'd3) && n < 10) begin
      tick;
      n++;
    end
    #2 reset_n = 1'b0;
    #1;
    n_cmp++;
    if ({rd_path, out_valid, out_data, out_index, out_last, busy, done} !== '0) begin
      n_err++;
      $display("FAIL reset_mid: got %h required 0", {rd_path, out_valid, out_data, out_index, out_last, busy, done});
    end
    sb.delete();
    a0 = acc_cnt;
    tick;
    tick;
    reset_n = 1'b1;
    repeat (5) tick;
    n_cmp++;
    if (busy !== 1'b0 || acc_cnt !== a0) begin
      n_err++;
      $display("FAIL reset_release: busy=%0b beats=%0d required 0/0", busy, acc_cnt - a0);
    end
    do_start(5'd0, 5'd1);
    wait_done(10, 1'b0, cyc);
    n_cmp++;
    if (acc_cnt - a0 !== 2 || sb.size() !== 0) begin
      n_err++;
      $display("FAIL reset_restart: beats=%0d left=%0d required 2/0", acc_cnt - a0, sb.size());
    end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    acc_cnt = 0;
    done_cnt = 0;
    held_v = 1'b0;
    held = '0;
    last_data = '0;
    reset_n = 1'b0;
    start = 1'b0;
    first_reg = '0;
    last_reg = '0;
    out_ready = 1'b0;
    we = 1'b0;
    wa = '0;
    wd = '0;
    for (int i = 0; i < 32; i++) regs[i] = '0;
    #2;
    test_reset;
    test_full;
    test_wrap;
    test_single_stall;
    test_back_pressure;
    test_coherency;
    test_reset_mid;
    tick;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
